// File: rtl/exp_diff_serial.sv
// Bit-serial exponent subtractor for the FP add/sub path.
// Produces A-B one bit per clock, LSB first, through a single full-subtractor
// cell, then (only when A<B) serially negates the raw difference to obtain
// the magnitude. Result registers are loaded only on entry to DONE, so the
// visible outputs keep the previous result while an operation is in flight.

module exp_diff_serial #(
    parameter int W     = 8,
    parameter int CNT_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic [W-1:0] mag,
    output logic         a_lt_b,
    output logic         zero
);

    // state | meaning
    // IDLE  | waiting for operands, in_ready high
    // SUB   | W cycles of serial subtract, LSB first
    // NEG   | W cycles of serial two's-complement negate (only when A<B)
    // DONE  | result presented, out_valid high until out_ready
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SUB  = 2'd1;
    localparam logic [1:0] NEG  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     a_sh;
    logic [W-1:0]     b_sh;
    logic [W-1:0]     d_sh;
    logic [W-1:0]     m_sh;
    logic             br;
    logic             carry;

    logic             d_bit;
    logic             br_next;
    logic             m_bit;
    logic             c_next;
    logic [W-1:0]     d_shifted;
    logic [W-1:0]     d_rot;
    logic [W-1:0]     m_shifted;
    logic             last;

    // Handshake flags decode state only; no path from in_valid/out_ready.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Shared serial cells: full subtractor for SUB, incrementer-style negate for NEG.
    always_comb begin
        d_bit     = a_sh[0] ^ b_sh[0] ^ br;
        br_next   = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
        m_bit     = ~d_sh[0] ^ carry;
        c_next    = ~d_sh[0] & carry;
        d_shifted = {d_bit, d_sh[W-1:1]};
        d_rot     = {d_sh[0], d_sh[W-1:1]};
        m_shifted = {m_bit, m_sh[W-1:1]};
        last      = (cnt == LAST);
    end

    // Sequencer and datapath; synchronous reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            br     <= 1'b0;
            carry  <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            d_sh   <= '0;
            m_sh   <= '0;
            diff   <= '0;
            mag    <= '0;
            a_lt_b <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        d_sh  <= '0;
                        br    <= 1'b0;
                        cnt   <= '0;
                        state <= SUB;
                    end
                end

                SUB: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    d_sh <= d_shifted;
                    br   <= br_next;
                    if (last) begin
                        cnt <= '0;
                        if (br_next) begin
                            // A<B: keep the final borrow in br until NEG finishes.
                            carry <= 1'b1;
                            m_sh  <= '0;
                            state <= NEG;
                        end else begin
                            diff   <= d_shifted;
                            mag    <= d_shifted;
                            zero   <= (d_shifted == '0);
                            a_lt_b <= 1'b0;
                            state  <= DONE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                NEG: begin
                    // Rotating d_sh leaves it unchanged after W cycles.
                    d_sh  <= d_rot;
                    m_sh  <= m_shifted;
                    carry <= c_next;
                    if (last) begin
                        cnt    <= '0;
                        diff   <= d_rot;
                        mag    <= m_shifted;
                        zero   <= (d_rot == '0);
                        a_lt_b <= br;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exp_diff_serial.sv
// Directed and randomized checks for exp_diff_serial (W=8).
// Cycle numbering: the cycle in which the operands are accepted is cycle 0;
// each following rising edge starts the next cycle.

module tb_exp_diff_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic [7:0] mag;
    logic       a_lt_b;
    logic       zero;

    int n_vec = 0;
    int n_err = 0;

    exp_diff_serial #(.W(8), .CNT_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
        .mag      (mag),
        .a_lt_b   (a_lt_b),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_diff"}, diff, 0);
        chk({tag, "_mag"}, mag, 0);
        chk({tag, "_a_lt_b"}, a_lt_b, 0);
        chk({tag, "_zero"}, zero, 0);
    endtask

    // Offer operands, wait for the result, hold out_ready low for 'hold'
    // cycles (optionally poking in_valid meanwhile), then complete the handshake.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb,
                          input int hold, input bit poke);
        logic [7:0] e_diff;
        logic [7:0] e_mag;
        logic       e_lt;
        int         cyc;
        int         n;
        e_diff = ta - tb;
        e_lt   = (ta < tb);
        e_mag  = e_lt ? (tb - ta) : (ta - tb);

        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", in_ready, 1);

        a = ta; b = tb; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        cyc = 1;
        chk("busy_in_ready", in_ready, 0);

        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency", cyc, e_lt ? 17 : 9);
        chk("diff", diff, e_diff);
        chk("mag", mag, e_mag);
        chk("a_lt_b", a_lt_b, e_lt);
        chk("zero", zero, (e_diff == 8'h00));

        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                in_valid = 1'b1; a = 8'h5A; b = 8'hA5;
            end
            @(negedge clk);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_diff", diff, e_diff);
            chk("hold_mag", mag, e_mag);
            chk("hold_a_lt_b", a_lt_b, e_lt);
        end

        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_out_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
        chk("post_diff_held", diff, e_diff);
    endtask

    // Accept an operation, then pulse rst after 'cycles' cycles in flight.
    task automatic abort_op(input logic [7:0] ta, input logic [7:0] tb,
                            input int cycles, input string tag);
        a = ta; b = tb; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 1; i < cycles; i++) @(negedge clk);
        chk({tag, "_busy"}, in_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_cleared(tag);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_cleared("reset");

        // out_ready with nothing to deliver is ignored
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_ready_in_ready", in_ready, 1);
        chk("idle_ready_out_valid", out_valid, 0);

        // T1 / T2 / T3
        run_op(8'h85, 8'h03, 0, 1'b0);
        run_op(8'h03, 8'h85, 0, 1'b0);
        run_op(8'h40, 8'h40, 0, 1'b0);
        run_op(8'h00, 8'hFF, 0, 1'b0);
        run_op(8'hFF, 8'h00, 0, 1'b0);
        run_op(8'hFF, 8'hFF, 0, 1'b0);
        run_op(8'h7F, 8'h80, 0, 1'b0);

        // T4 backpressure with in_valid poked while DONE
        run_op(8'h03, 8'h85, 5, 1'b1);
        @(negedge clk);
        chk("t4_no_spurious_start", in_ready, 1);

        // T5 aborts in SUB cycle 4 and NEG cycle 3 (NEG cycle 3 = cycle 11)
        abort_op(8'h85, 8'h03, 4, "rst_sub");
        abort_op(8'h03, 8'h85, 11, "rst_neg");
        run_op(8'h10, 8'h01, 0, 1'b0);

        // T6 random operands with random gaps and backpressure
        for (int k = 0; k < 1500; k++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) @(negedge clk);
            run_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
